// File: rtl/fire_sensor_conditioner_pkg.sv
// rtl/fire_sensor_conditioner_pkg.sv - shared state encoding and helpers for the flame-sensor front end
package fire_sensor_conditioner_pkg;

  typedef enum logic [1:0] {
    FS_SAFE         = 2'd0,
    FS_PEND         = 2'd1,
    FS_ALARM        = 2'd2,
    FS_RELEASE_WAIT = 2'd3
  } fs_state_e;

  // LED blink half-period is 2^LED_DIV_W clocks while waiting for ack.
  localparam int LED_DIV_W = 12;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fire_sensor_conditioner_sync_2ff.sv
// rtl/fire_sensor_conditioner_sync_2ff.sv - two-flop synchroniser for a single asynchronous plant input
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fire_sensor_conditioner.sv
// rtl/fire_sensor_conditioner.sv - debounces and latches the flame sensor into the active-low fire_n alarm
module fire_sensor_conditioner
  import fire_sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter bit SENSOR_ACTIVE_LOW = 1'b1,
  parameter bit ACK_REQUIRED      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_raw,
  input  logic       ack,
  output logic       fire_n,
  output logic       alarm_led,
  output logic [7:0] fire_count,
  output logic [1:0] state_dbg
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  fs_state_e            state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic                 synced, act, count_inc, led_next, blink_wrap;
  logic [LED_DIV_W-1:0] blink;

  // Flops idle at the no-flame level so reset never looks like a detection.
  sync_2ff #(.RESET_VAL(SENSOR_ACTIVE_LOW)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sensor_raw),
    .q    (synced)
  );

  assign act        = synced ^ SENSOR_ACTIVE_LOW;
  assign blink_wrap = (state == FS_RELEASE_WAIT) && (&blink);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    count_inc  = 1'b0;
    case (state)
      FS_SAFE: begin
        if (act) begin
          state_next = FS_PEND;
          cnt_next   = CNT_ONE;
        end
      end
      FS_PEND: begin
        if (!act) begin
          state_next = FS_SAFE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = FS_ALARM;
          cnt_next   = '0;
          count_inc  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      FS_ALARM: begin
        if (act) begin
          cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = ACK_REQUIRED ? FS_RELEASE_WAIT : FS_SAFE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      FS_RELEASE_WAIT: begin
        // Flame re-detection outranks a simultaneous ack.
        if (act) begin
          state_next = FS_ALARM;
          cnt_next   = '0;
        end else if (ack) begin
          state_next = FS_SAFE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = FS_SAFE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    led_next = 1'b0;
    case (state_next)
      FS_ALARM:        led_next = 1'b1;
      FS_RELEASE_WAIT: led_next = alarm_led ^ blink_wrap;
      default:         led_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FS_SAFE;
      cnt        <= '0;
      fire_n     <= 1'b1;
      alarm_led  <= 1'b0;
      fire_count <= 8'd0;
      blink      <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      fire_n    <= !((state_next == FS_ALARM) || (state_next == FS_RELEASE_WAIT));
      alarm_led <= led_next;
      if (count_inc) begin
        fire_count <= sat_inc8(fire_count);
      end
      blink <= (state == FS_RELEASE_WAIT) ? blink + LED_DIV_W'(1) : '0;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_fire_sensor_conditioner.sv
// tb/tb_fire_sensor_conditioner.sv - randomized self-checking bench against a run-length behavioural model
module tb_fire_sensor_conditioner;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sensor_raw;
  logic       ack;
  logic       fire_n;
  logic       alarm_led;
  logic [7:0] fire_count;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Model: pin history, alarm/waiting flags, run lengths of flame and clear samples.
  bit m_s1, m_s2, m_alarm, m_wait;
  int m_frun, m_crun, m_count, m_wedges;

  fire_sensor_conditioner #(
    .DEBOUNCE_CYCLES  (D),
    .SENSOR_ACTIVE_LOW(1'b1),
    .ACK_REQUIRED     (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sensor_raw(sensor_raw),
    .ack       (ack),
    .fire_n    (fire_n),
    .alarm_led (alarm_led),
    .fire_count(fire_count),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit a);
    bit act;
    if (!r) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_alarm = 0; m_wait = 0;
      m_frun = 0; m_crun = 0; m_count = 0; m_wedges = 0;
      return;
    end
    act  = (m_s2 == 1'b0);
    m_s2 = m_s1;
    m_s1 = s;
    if (m_wait) begin
      if (act) begin
        m_wait = 0; m_crun = 0;
      end else if (a) begin
        m_wait = 0; m_alarm = 0; m_frun = 0;
      end else begin
        m_wedges++;
      end
    end else if (m_alarm) begin
      if (act) m_crun = 0;
      else begin
        m_crun++;
        if (m_crun == D) begin
          m_wait = 1; m_wedges = 0;
        end
      end
    end else begin
      if (act) begin
        m_frun++;
        if (m_frun == D) begin
          m_alarm = 1; m_frun = 0; m_crun = 0;
          if (m_count < 255) m_count++;
        end
      end else begin
        m_frun = 0;
      end
    end
  endtask

  function automatic int exp_state();
    return m_wait ? 3 : (m_alarm ? 2 : (m_frun > 0 ? 1 : 0));
  endfunction

  function automatic int exp_led();
    return m_wait ? (1 ^ ((m_wedges / 4096) % 2)) : (m_alarm ? 1 : 0);
  endfunction

  task automatic tick(input bit s, input bit a, input bit r);
    rst_n      = r;
    sensor_raw = s;
    ack        = a;
    @(posedge clk);
    model_step(r, s, a);
    #1;
    check("state", 32'(state_dbg), 32'(exp_state()));
    check("fire_n", 32'(fire_n), 32'(!m_alarm));
    check("count", 32'(fire_count), 32'(m_count));
    check("led", 32'(alarm_led), 32'(exp_led()));
  endtask

  initial begin
    bit saw_pend;
    bit s_rand;
    int saved;
    int len;
    rst_n = 1'b0; sensor_raw = 1'b1; ack = 1'b0;
    model_step(1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    check("reset_state", 32'(state_dbg), 32'd0);
    check("reset_fire_n", 32'(fire_n), 32'd1);

    repeat (100) tick(1'b1, 1'b0, 1'b1);

    // Glitch shorter than the debounce window.
    saw_pend = 0;
    repeat (5) begin
      tick(1'b0, 1'b0, 1'b1);
      if (state_dbg == 2'd1) saw_pend = 1;
    end
    repeat (20) begin
      tick(1'b1, 1'b0, 1'b1);
      if (state_dbg == 2'd1) saw_pend = 1;
    end
    check("glitch_pend_seen", 32'(saw_pend), 32'd1);
    check("glitch_count", 32'(fire_count), 32'd0);

    // Latency: flame first sampled at edge k, fire_n drops after edge k+9.
    tick(1'b0, 1'b0, 1'b1);
    repeat (8) tick(1'b0, 1'b0, 1'b1);
    check("latency_pre", 32'(fire_n), 32'd1);
    tick(1'b0, 1'b0, 1'b1);
    check("latency_fire_n", 32'(fire_n), 32'd0);
    check("latency_count", 32'(fire_count), 32'd1);
    check("latency_led", 32'(alarm_led), 32'd1);

    // Clear then ack pulse.
    repeat (12) tick(1'b1, 1'b0, 1'b1);
    check("rw_state", 32'(state_dbg), 32'd3);
    check("rw_fire_n", 32'(fire_n), 32'd0);
    tick(1'b1, 1'b1, 1'b1);
    check("ack_state", 32'(state_dbg), 32'd0);
    check("ack_fire_n", 32'(fire_n), 32'd1);

    // Flame and ack coincide at the synced level in RELEASE_WAIT.
    repeat (12) tick(1'b0, 1'b0, 1'b1);
    repeat (12) tick(1'b1, 1'b0, 1'b1);
    saved = int'(fire_count);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("prio_still_rw", 32'(state_dbg), 32'd3);
    tick(1'b0, 1'b1, 1'b1);
    check("prio_state", 32'(state_dbg), 32'd2);
    check("prio_fire_n", 32'(fire_n), 32'd0);
    check("prio_count", 32'(fire_count), 32'(saved));

    // Ack held through ALARM releases one cycle after RELEASE_WAIT entry.
    repeat (9) tick(1'b1, 1'b1, 1'b1);
    check("held_ack_alarm", 32'(state_dbg), 32'd2);
    tick(1'b1, 1'b1, 1'b1);
    check("held_ack_rw", 32'(state_dbg), 32'd3);
    tick(1'b1, 1'b1, 1'b1);
    check("held_ack_safe", 32'(state_dbg), 32'd0);

    // LED blink while waiting for ack.
    repeat (12) tick(1'b0, 1'b0, 1'b1);
    repeat (10) tick(1'b1, 1'b0, 1'b1);
    repeat (5000) tick(1'b1, 1'b0, 1'b1);
    check("blink_led", 32'(alarm_led), 32'd0);
    tick(1'b1, 1'b1, 1'b1);

    // Random segments.
    for (int i = 0; i < 300; i++) begin
      s_rand = 1'($urandom_range(0, 1));
      len    = $urandom_range(1, 14);
      for (int j = 0; j < len; j++) tick(s_rand, ($urandom_range(0, 3) == 0), 1'b1);
    end

    // Saturation.
    for (int i = 0; i < 260; i++) begin
      repeat (12) tick(1'b0, 1'b0, 1'b1);
      repeat (12) tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b1);
    end
    check("sat_count", 32'(fire_count), 32'd255);

    repeat (12) tick(1'b0, 1'b0, 1'b1);
    check("mid_alarm", 32'(state_dbg), 32'd2);
    tick(1'b0, 1'b0, 1'b0);
    check("rst_fire_n", 32'(fire_n), 32'd1);
    check("rst_count", 32'(fire_count), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
